// File: rtl/calc_operand_sequencer.sv
// calc_operand_sequencer: collects A, B and add/sub over debounced ENTER presses
// and fires a one-cycle load to the downstream adder result register.
module calc_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       op_sub,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       Cin,
    output logic       enable,
    output logic [1:0] state
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    typedef enum logic [1:0] {S_A = 2'b00, S_B = 2'b01, S_FIRE = 2'b10, S_SHOW = 2'b11} state_t;
    state_t cur, nxt;
    logic [1:0] enter_sync, clear_sync;
    logic [CW-1:0] cnt;
    logic db, db_q, press, clr, lvl, sub;
    assign lvl = enter_sync[1];
    assign clr = clear_sync[1];
    assign press = db & ~db_q;
    assign state = cur;
    assign Cin = sub;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            enter_sync <= '0;
            clear_sync <= '0;
            cnt <= '0;
            db <= 1'b0;
            db_q <= 1'b0;
        end else begin
            enter_sync <= {enter_sync[0], btn_enter};
            clear_sync <= {clear_sync[0], btn_clear};
            db_q <= db;
            if (lvl == db) cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db <= lvl;
                cnt <= '0;
            end else cnt <= cnt + CW'(1);
        end
    // S_SHOW + 1 wraps back to S_A, so every advance is a simple increment
    always_comb nxt = clr ? S_A : (cur == S_FIRE || press) ? state_t'(cur + 2'd1) : cur;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cur <= S_A;
            A <= '0;
            B <= '0;
            sub <= 1'b0;
            enable <= 1'b0;
        end else begin
            cur <= nxt;
            enable <= nxt == S_FIRE;
            if (clr || (press && cur == S_SHOW)) begin
                A <= '0;
                B <= '0;
                sub <= 1'b0;
            end else if (press && cur == S_A) A <= sw;
            else if (press && cur == S_B) begin
                sub <= op_sub;
                B <= op_sub ? ~sw : sw;
            end
        end
endmodule
